// File: rtl/axis_frame_checker_if.sv
// AXI4-Stream bundle between ft_axi_fifo's m_axis and the frame checker.
// The master drives payload and tvalid; the slave returns tready.
interface axis_frame_checker_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDATA_BYTES = 8
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TDATA_BYTES-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_frame_checker.sv
// Stream sink with rotating tready backpressure, per-frame sequence,
// high-word and tkeep checking, saturating stats and board LEDs.
module axis_frame_checker #(
    parameter int         TDATA_WIDTH   = 64,
    parameter int         TDATA_BYTES   = 8,
    parameter int         SEQ_WIDTH     = 32,
    parameter int         CNT_WIDTH     = 32,
    parameter logic [7:0] READY_PATTERN = 8'hFF
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_aresetn,
    axis_frame_checker_if.slave  s_axis,
    input  logic                 enable,
    input  logic                 clear_stats,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [2:0]           last_err_code,
    output logic                 busy,
    output logic [3:0]           leds_4bits_tri_o
);
    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        DRAIN
    } state_t;

    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_SEQ  = 3'd1;
    localparam logic [2:0] ERR_HI   = 3'd2;
    localparam logic [2:0] ERR_KEEP = 3'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 r_state;
    logic [7:0]             r_pat;
    logic                   r_tready;
    logic [SEQ_WIDTH-1:0]   r_exp_lo;
    logic [SEQ_WIDTH-1:0]   r_ref_hi;
    logic [CNT_WIDTH-1:0]   r_beat_cnt;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;
    logic [CNT_WIDTH-1:0]   r_err_cnt;
    logic [2:0]             r_err_code;

    logic                   w_accept;
    logic [SEQ_WIDTH-1:0]   w_lo;
    logic [SEQ_WIDTH-1:0]   w_hi;
    logic [SEQ_WIDTH-1:0]   w_lo_next;
    logic [TDATA_BYTES-1:0] w_keep_p1;
    logic                   w_keep_ok;
    logic [2:0]             w_err;

    assign w_accept  = s_axis.tvalid & r_tready;
    assign w_lo      = s_axis.tdata[SEQ_WIDTH-1:0];
    assign w_hi      = s_axis.tdata[2*SEQ_WIDTH-1:SEQ_WIDTH];
    assign w_lo_next = w_lo + SEQ_WIDTH'(1);
    assign w_keep_p1 = s_axis.tkeep + TDATA_BYTES'(1);

    // Last beat must be a nonzero 2^n-1 mask; others must be full.
    assign w_keep_ok = s_axis.tlast
                     ? ((|s_axis.tkeep) &&
                        ((s_axis.tkeep & w_keep_p1) == '0))
                     : (&s_axis.tkeep);

    always_comb begin
        w_err = ERR_NONE;
        if (r_state == IDLE) begin
            if (!w_keep_ok) begin
                w_err = ERR_KEEP;
            end
        end else if (r_state == IN_FRAME) begin
            priority case (1'b1)
                !w_keep_ok:         w_err = ERR_KEEP;
                w_lo != r_exp_lo:   w_err = ERR_SEQ;
                w_hi != r_ref_hi:   w_err = ERR_HI;
                default:            w_err = ERR_NONE;
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_aresetn) begin
        if (s_axis_aresetn) begin
            r_state  <= IDLE;
            r_pat    <= READY_PATTERN;
            r_tready <= 1'b0;
            r_exp_lo <= '0;
            r_ref_hi <= '0;
        end else begin
            r_tready <= enable & r_pat[0];
            if (enable) begin
                r_pat <= {r_pat[0], r_pat[7:1]};
            end
            if (w_accept) begin
                unique case (r_state)
                    IDLE: begin
                        r_exp_lo <= w_lo_next;
                        r_ref_hi <= w_hi;
                        if (!s_axis.tlast) begin
                            r_state <= (w_err != ERR_NONE)
                                     ? DRAIN : IN_FRAME;
                        end
                    end
                    IN_FRAME: begin
                        r_exp_lo <= w_lo_next;
                        if (s_axis.tlast) begin
                            r_state <= IDLE;
                        end else if (w_err != ERR_NONE) begin
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (s_axis.tlast) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // A same-cycle clear discards the beat's contribution.
    always_ff @(posedge s_axis_aclk or posedge s_axis_aresetn) begin
        if (s_axis_aresetn) begin
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_err_code  <= ERR_NONE;
        end else if (clear_stats) begin
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_err_code  <= ERR_NONE;
        end else if (w_accept) begin
            if (r_beat_cnt != CNT_MAX) begin
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
            if (s_axis.tlast && (r_frame_cnt != CNT_MAX)) begin
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            end
            if (w_err != ERR_NONE) begin
                r_err_code <= w_err;
                if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign s_axis.tready    = r_tready;
    assign beat_count       = r_beat_cnt;
    assign frame_count      = r_frame_cnt;
    assign err_count        = r_err_cnt;
    assign last_err_code    = r_err_code;
    assign busy             = (r_state != IDLE);
    assign leds_4bits_tri_o = {r_frame_cnt[1:0], (r_err_cnt != '0), busy};
endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: frame-level reference model compared
// every cycle, plus directed frames and literal expectations.
module tb_axis_frame_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en0, en1, clr0, clr1;
    bit   en_rand, en_force;

    axis_frame_checker_if #(.TDATA_WIDTH(64), .TDATA_BYTES(8)) ax0 ();
    axis_frame_checker_if #(.TDATA_WIDTH(64), .TDATA_BYTES(8)) ax1 ();

    logic [31:0] b0, f0, e0;
    logic [2:0]  c0;
    logic        busy0;
    logic [3:0]  led0;
    logic [3:0]  b1, f1, e1;
    logic [2:0]  c1;
    logic        busy1;
    logic [3:0]  led1;

    axis_frame_checker #(.READY_PATTERN(8'hFF)) u_dut0 (
        .s_axis_aclk      (clk),
        .s_axis_aresetn   (rst),
        .s_axis           (ax0),
        .enable           (en0),
        .clear_stats      (clr0),
        .beat_count       (b0),
        .frame_count      (f0),
        .err_count        (e0),
        .last_err_code    (c0),
        .busy             (busy0),
        .leds_4bits_tri_o (led0)
    );

    axis_frame_checker #(.READY_PATTERN(8'hAA), .CNT_WIDTH(4)) u_dut1 (
        .s_axis_aclk      (clk),
        .s_axis_aresetn   (rst),
        .s_axis           (ax1),
        .enable           (en1),
        .clear_stats      (clr1),
        .beat_count       (b1),
        .frame_count      (f1),
        .err_count        (e1),
        .last_err_code    (c1),
        .busy             (busy1),
        .leds_4bits_tri_o (led1)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // Reference model for dut0, in terms of frames and rules.
    localparam longint MAX32 = 64'hFFFF_FFFF;
    logic [7:0]  pat0 = 8'hFF;
    bit          m_tready, m_in_frame, m_drain;
    int          m_k;
    logic [31:0] m_exp, m_ref;
    longint      m_beats, m_frames, m_errs;
    int          m_code;

    function automatic bit keep_ok(input logic [7:0] k, input bit last);
        if (!last) return k == 8'hFF;
        for (int n = 1; n <= 8; n++)
            if (k == 8'((1 << n) - 1)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_tready = 0; m_in_frame = 0; m_drain = 0; m_k = 0;
        m_exp = 0; m_ref = 0;
        m_beats = 0; m_frames = 0; m_errs = 0; m_code = 0;
    endtask

    task automatic model_step();
        bit          acc, last;
        logic [31:0] lo, hi;
        logic [7:0]  kp;
        int          e;
        acc  = ax0.tvalid && m_tready;
        lo   = ax0.tdata[31:0];
        hi   = ax0.tdata[63:32];
        kp   = ax0.tkeep;
        last = ax0.tlast;
        e    = 0;
        if (acc) begin
            if (!m_in_frame) begin
                if (!keep_ok(kp, last)) e = 3;
                m_exp = lo + 32'd1;
                m_ref = hi;
            end else if (!m_drain) begin
                if (!keep_ok(kp, last)) e = 3;
                else if (lo != m_exp) e = 1;
                else if (hi != m_ref) e = 2;
                m_exp = lo + 32'd1;
            end
            if (last) begin
                m_in_frame = 0;
                m_drain = 0;
            end else begin
                m_in_frame = 1;
                if (e != 0) m_drain = 1;
            end
        end
        if (clr0) begin
            m_beats = 0; m_frames = 0; m_errs = 0; m_code = 0;
        end else if (acc) begin
            if (m_beats < MAX32) m_beats++;
            if (last && m_frames < MAX32) m_frames++;
            if (e != 0) begin
                m_code = e;
                if (m_errs < MAX32) m_errs++;
            end
        end
        m_tready = en0 && pat0[m_k % 8];
        if (en0) m_k++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("tready", ax0.tready, m_tready);
            chk("beat_count", b0, m_beats);
            chk("frame_count", f0, m_frames);
            chk("err_count", e0, m_errs);
            chk("last_err_code", c0, m_code);
            chk("busy", busy0, m_in_frame);
            chk("leds", led0, {m_frames[1:0], m_errs != 0, m_in_frame});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            en0 = en_rand ? ($urandom_range(0, 3) != 0) : en_force;
        end
    end

    task automatic beat0(input logic [31:0] lo, input logic [31:0] hi,
                         input logic [7:0] keep, input bit last,
                         input bit clr = 0);
        int n = 0;
        @(negedge clk);
        ax0.tdata  = {hi, lo};
        ax0.tkeep  = keep;
        ax0.tlast  = last;
        ax0.tvalid = 1'b1;
        clr0       = clr;
        while (!ax0.tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("beat0_timeout", n, 0);
        @(posedge clk);
        #1;
        ax0.tvalid = 1'b0;
        ax0.tlast  = 1'b0;
        clr0       = 1'b0;
    endtask

    task automatic pulse_clr0();
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
    endtask

    logic [7:0] pat1 = 8'hAA;
    bit         hist1 [0:63];

    task automatic run1(input int nb, input logic [31:0] start,
                        output int ncyc);
        int got = 0;
        int c = 0;
        @(negedge clk);
        ax1.tdata  = {32'd7, start};
        ax1.tkeep  = 8'hFF;
        ax1.tlast  = (nb == 1);
        ax1.tvalid = 1'b1;
        en1        = 1'b1;
        while (got < nb && c < 64) begin
            hist1[c] = ax1.tready;
            if (ax1.tready) begin
                @(posedge clk);
                #1;
                got++;
                ax1.tdata[31:0] = start + 32'(got);
                ax1.tlast = (got == nb - 1);
            end
            @(negedge clk);
            c++;
        end
        ax1.tvalid = 1'b0;
        ax1.tlast  = 1'b0;
        ncyc = c;
        chk("dut1_accepts", got, nb);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        rst = 1'b1;
        en_force = 0; en_rand = 0;
        en1 = 0; clr0 = 0; clr1 = 0;
        ax0.tvalid = 0; ax0.tlast = 0; ax0.tdata = '0; ax0.tkeep = '0;
        ax1.tvalid = 0; ax1.tlast = 0; ax1.tdata = '0; ax1.tkeep = '0;
        repeat (2) @(negedge clk);
        chk("rst_tready", ax0.tready, 0);
        chk("rst_beats", b0, 0);
        chk("rst_leds", led0, 0);
        #2 rst = 1'b0;
        en_force = 1;
        repeat (2) @(negedge clk);

        for (int i = 1; i <= 16; i++)
            beat0(32'(i), 32'd7, 8'hFF, i == 16);
        @(negedge clk);
        chk("t1_beats", b0, 16);
        chk("t1_frames", f0, 1);
        chk("t1_errs", e0, 0);

        pulse_clr0();
        beat0(32'd3, 32'd7, 8'hFF, 0);
        beat0(32'd5, 32'd7, 8'hFF, 0);
        @(negedge clk);
        chk("t2_busy_drain", busy0, 1);
        chk("t2_errs", e0, 1);
        chk("t2_code", c0, 1);
        beat0(32'd6, 32'd7, 8'hFF, 1);
        @(negedge clk);
        chk("t2_busy_after", busy0, 0);
        chk("t2_frames", f0, 1);

        pulse_clr0();
        beat0(32'hFFFF_FFFE, 32'd7, 8'hFF, 0);
        beat0(32'hFFFF_FFFF, 32'd7, 8'hFF, 0);
        beat0(32'h0000_0000, 32'd7, 8'hFF, 1);
        @(negedge clk);
        chk("t3_errs_wrap", e0, 0);
        chk("t3_frames", f0, 1);

        pulse_clr0();
        beat0(32'd1, 32'd7, 8'hFF, 0);
        beat0(32'd2, 32'd7, 8'h0F, 0);
        beat0(32'd3, 32'd7, 8'hFF, 1);
        @(negedge clk);
        chk("t5a_code", c0, 3);
        beat0(32'd10, 32'd7, 8'hFF, 0);
        beat0(32'd11, 32'd7, 8'h0F, 1);
        @(negedge clk);
        chk("t5b_errs", e0, 1);
        beat0(32'd20, 32'd7, 8'hFF, 0);
        beat0(32'd21, 32'd7, 8'h0B, 1);
        @(negedge clk);
        chk("t5c_errs", e0, 2);
        chk("t5c_code", c0, 3);
        beat0(32'd30, 32'd7, 8'hFF, 0);
        beat0(32'd32, 32'd7, 8'h03, 0);
        beat0(32'd33, 32'd7, 8'hFF, 1);
        @(negedge clk);
        chk("t5d_errs", e0, 3);
        chk("t5d_code", c0, 3);

        en_rand = 1;
        for (int f = 0; f < 60; f++) begin
            int len = $urandom_range(1, 6);
            logic [31:0] hi = $urandom;
            logic [31:0] lo = ($urandom_range(0, 3) == 0)
                            ? 32'hFFFF_FFFD : $urandom;
            for (int b = 0; b < len; b++) begin
                int kind = $urandom_range(0, 19);
                bit last = (b == len - 1);
                logic [7:0] kp = 8'hFF;
                logic [31:0] h = hi;
                if (last)
                    kp = (kind == 0) ? 8'($urandom)
                                     : 8'((1 << $urandom_range(1, 8)) - 1);
                else if (kind == 1)
                    kp = 8'($urandom);
                if (kind == 2) lo = lo + 32'd1;
                if (kind == 3) h = hi ^ 32'h0000_0100;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                beat0(lo, h, kp, last);
                lo = lo + 32'd1;
            end
        end
        en_rand = 0;
        repeat (2) @(negedge clk);

        beat0(32'd5, 32'd7, 8'hFF, 0);
        beat0(32'd6, 32'd7, 8'hFF, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", busy0, 0);
        #2 rst = 1'b0;
        beat0(32'd100, 32'd7, 8'hFF, 0);
        beat0(32'd101, 32'd7, 8'hFF, 0);
        beat0(32'd102, 32'd7, 8'hFF, 1);
        @(negedge clk);
        chk("t6_errs", e0, 0);
        chk("t6_beats", b0, 3);
        beat0(32'd200, 32'd9, 8'hFF, 1, 1);
        @(negedge clk);
        chk("t6_clr_beats", b0, 0);
        chk("t6_clr_frames", f0, 0);

        run1(8, 32'd1, ncyc);
        chk("t4_span", ncyc, 17);
        for (int c = 0; c < 17; c++)
            chk($sformatf("t4_tready_%0d", c), hist1[c],
                (c == 0) ? 1'b0 : pat1[(c - 1) % 8]);
        chk("t4_beats", b1, 8);
        chk("t4_frames", f1, 1);
        chk("t4_errs", e1, 0);
        run1(20, 32'd100, ncyc);
        chk("sat_beats", b1, 15);
        chk("sat_frames", f1, 2);
        chk("sat_leds", led1, 4'b1000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
